// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and load-use hazard unit for the in-order pipeline.
//   It tracks the destinations of the FWD_DEPTH instructions that have left EX
//   in a private shift register. It does not look at the rd fields of the
//   later pipeline stages. From those records it selects, for each EX source
//   operand, where that operand should be taken from. When an operand
//   depends on a load whose data is not yet available, it requests a stall.
//
// Parameters
//   NUM_SRC           source operands of the EX instruction
//   FWD_DEPTH         tracked stages after EX (1 = MEM, 2 = WB, ...), 1..7
//   REG_AW            register address width
//   LOAD_READY_STAGE  first tracked stage where load data is forwardable
//
// Ports
//   clk           rising-edge clock
//   arst          asynchronous reset, active high; clears every record
//   ex_valid      EX holds a real instruction
//   ex_rd         EX destination register
//   ex_reg_write  EX instruction writes the register file
//   ex_mem_read   EX instruction is a load
//   ex_rs         EX source registers, operand i at [i*REG_AW +: REG_AW]
//   hold          global freeze: records keep their values
//   flush         invalidate all in-flight records (wins over hold)
//   fwd_sel       per-operand select, 0 = regfile, k = result of stage k
//   stall         load-use stall request (combinational)
//
// Optional build macro FWD_HAZARD_PERF_EN adds two free-running counters:
//   perf_stall_cnt  clocks with stall=1 and hold=0
//   perf_fwd_cnt    issued EX instructions that used at least one forward

module fwd_hazard_unit #(
  parameter int unsigned NUM_SRC          = 2,
  parameter int unsigned FWD_DEPTH        = 2,
  parameter int unsigned REG_AW           = 5,
  parameter int unsigned LOAD_READY_STAGE = 2,
  localparam int unsigned SW              = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      ex_valid,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic                      hold,
  input  logic                      flush,
  output logic [NUM_SRC*SW-1:0]     fwd_sel,
  output logic                      stall
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_fwd_cnt
`endif
);

  // Illegal parameter values stop elaboration. The check instantiates a
  // module that does not exist.
  if (FWD_DEPTH < 1 || FWD_DEPTH > 7) begin : g_bad_fwd_depth
    fwd_hazard_unit_illegal_fwd_depth u_bad ();
  end
  if (LOAD_READY_STAGE < 1 || LOAD_READY_STAGE > FWD_DEPTH) begin : g_bad_ready
    fwd_hazard_unit_illegal_load_ready_stage u_bad ();
  end

  // Record storage. Index k holds stage k+1, so index 0 is the stage right
  // after EX.
  logic [FWD_DEPTH-1:0]             rec_valid;
  logic [FWD_DEPTH-1:0]             rec_ld;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] rec_rd;

  logic [FWD_DEPTH-1:0]             rec_cand;
  logic [FWD_DEPTH-1:0]             rec_ready;
  logic [NUM_SRC-1:0]               hazard;
  logic [NUM_SRC*SW-1:0]            sel;
  logic                             stage1_valid;

  // Per-record qualifiers. A record with rd = x0 is never a write candidate.
  // Load data becomes usable only once the load reaches LOAD_READY_STAGE.
  always_comb begin
    rec_cand  = '0;
    rec_ready = '0;
    for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
      rec_cand[k]  = rec_valid[k] && (rec_rd[k] != '0);
      rec_ready[k] = !rec_ld[k] || ((k + 1) >= LOAD_READY_STAGE);
    end
  end

  // Operand select. Only the youngest matching record matters. If that
  // record is an unready load, the operand raises a hazard. It does not
  // fall back to an older record for the same register, because that value
  // would be stale.
  always_comb begin : fwd_search
    logic [REG_AW-1:0] rs;
    logic              found;
    sel    = '0;
    hazard = '0;
    rs     = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      rs    = ex_rs[i*REG_AW +: REG_AW];
      found = 1'b0;
      for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
        if (!found && rs != '0 && rec_cand[k] && rec_rd[k] == rs) begin
          found = 1'b1;
          if (rec_ready[k]) begin
            sel[i*SW +: SW] = SW'(k + 1);
          end else begin
            hazard[i] = 1'b1;
          end
        end
      end
    end
  end

  assign fwd_sel = sel;
  assign stall   = ex_valid & (|hazard);

  // While stalled, EX is held by the consumer. A bubble enters stage 1 so
  // the held instruction is not recorded twice.
  assign stage1_valid = ex_valid & ex_reg_write & ~stall;

  // Record shift register. Priority is flush, then hold, then shift.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rec_valid <= '0;
      rec_ld    <= '0;
      rec_rd    <= '0;
    end else if (flush) begin
      rec_valid <= '0;
    end else if (!hold) begin
      for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
        rec_valid[k] <= rec_valid[k-1];
        rec_ld[k]    <= rec_ld[k-1];
        rec_rd[k]    <= rec_rd[k-1];
      end
      rec_valid[0] <= stage1_valid;
      rec_ld[0]    <= ex_mem_read;
      rec_rd[0]    <= ex_rd;
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  // Both counters wrap around; they do not saturate.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall && !hold) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (ex_valid && !stall && !hold && (sel != '0)) begin
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic       clk;
  logic       arst;

  // Default-parameter DUT (NUM_SRC=2, FWD_DEPTH=2, LOAD_READY_STAGE=2)
  logic       ex_valid, ex_reg_write, ex_mem_read, hold, flush;
  logic [4:0] ex_rd;
  logic [9:0] ex_rs;
  logic [3:0] fwd_sel;
  logic       stall;

  // FWD_DEPTH=3, LOAD_READY_STAGE=3 DUT
  logic       ex_valid3, ex_reg_write3, ex_mem_read3, hold3, flush3;
  logic [4:0] ex_rd3;
  logic [9:0] ex_rs3;
  logic [3:0] fwd_sel3;
  logic       stall3;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_fwd_cnt, perf_stall_cnt3, perf_fwd_cnt3;
`endif

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit u_dut (
    .clk(clk), .arst(arst), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rs(ex_rs),
    .hold(hold), .flush(flush), .fwd_sel(fwd_sel), .stall(stall)
`ifdef FWD_HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  fwd_hazard_unit #(.NUM_SRC(2), .FWD_DEPTH(3), .REG_AW(5), .LOAD_READY_STAGE(3)) u_dut3 (
    .clk(clk), .arst(arst), .ex_valid(ex_valid3), .ex_rd(ex_rd3),
    .ex_reg_write(ex_reg_write3), .ex_mem_read(ex_mem_read3), .ex_rs(ex_rs3),
    .hold(hold3), .flush(flush3), .fwd_sel(fwd_sel3), .stall(stall3)
`ifdef FWD_HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt3), .perf_fwd_cnt(perf_fwd_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic       hold;
    logic       flush;
    logic [1:0] e0;
    logic [1:0] e1;
    logic       es;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [4:0] rd, input logic rw,
                     input logic mr, input logic [4:0] rs0, input logic [4:0] rs1,
                     input logic h, input logic f, input logic [1:0] e0,
                     input logic [1:0] e1, input logic es);
    vec_t t;
    t.v = v; t.rd = rd; t.rw = rw; t.mr = mr; t.rs0 = rs0; t.rs1 = rs1;
    t.hold = h; t.flush = f; t.e0 = e0; t.e1 = e1; t.es = es;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic h, input logic f);
    ex_valid = v; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr;
    ex_rs = {rs1, rs0}; hold = h; flush = f;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    arst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    ex_valid3 = 0; ex_rd3 = 0; ex_reg_write3 = 0; ex_mem_read3 = 0;
    ex_rs3 = '0; hold3 = 0; flush3 = 0;

    // Each row: EX inputs for one cycle, then the expected sel0, sel1 and stall.
    // Expected values follow from the records left by the earlier rows.
    //   v  rd rw mr rs0 rs1 h f  e0 e1 es
    add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); //  0 ALU writes x5
    add(1, 6, 0, 0, 0, 5, 0, 0, 0, 1, 0); //  1 x5 in stage 1
    add(1, 6, 0, 0, 0, 5, 0, 0, 0, 2, 0); //  2 x5 in stage 2
    add(1, 6, 0, 0, 0, 5, 0, 0, 0, 0, 0); //  3 x5 gone
    add(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0); //  4 load x7
    add(1, 6, 0, 0, 7, 0, 0, 0, 0, 0, 1); //  5 load-use stall
    add(1, 6, 0, 0, 7, 0, 0, 0, 2, 0, 0); //  6 forwarded from stage 2
    add(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0); //  7 load x7
    add(1, 6, 0, 0, 7, 0, 1, 0, 0, 0, 1); //  8 stall while holding
    add(1, 6, 0, 0, 7, 0, 1, 0, 0, 0, 1); //  9
    add(1, 6, 0, 0, 7, 0, 1, 0, 0, 0, 1); // 10
    add(1, 6, 0, 0, 7, 0, 0, 0, 0, 0, 1); // 11 fourth stall cycle
    add(1, 6, 0, 0, 7, 0, 0, 0, 2, 0, 0); // 12
    add(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0); // 13 ALU x3
    add(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0); // 14 ALU x3 again
    add(1, 6, 0, 0, 3, 3, 0, 0, 1, 1, 0); // 15 youngest wins
    add(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); // 16 load to x0
    add(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0); // 17 x0 never forwards/stalls
    add(1, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0); // 18 load x4
    add(0, 6, 0, 0, 4, 0, 0, 0, 0, 0, 0); // 19 ex_valid=0: no stall
    add(1, 6, 0, 0, 4, 0, 0, 0, 2, 0, 0); // 20
    add(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0); // 21 ALU x8
    add(1, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0); // 22 load x8
    add(1, 6, 0, 0, 8, 0, 0, 0, 0, 0, 1); // 23 no fall-through to stage 2
    add(1, 6, 0, 0, 8, 0, 0, 0, 2, 0, 0); // 24
    add(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0); // 25 load x7
    add(1, 6, 0, 0, 7, 0, 0, 1, 0, 0, 1); // 26 stall + flush
    add(1, 6, 0, 0, 7, 0, 0, 0, 0, 0, 0); // 27 flushed: nothing left
    add(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0); // 28 load x7
    add(1, 6, 0, 0, 7, 0, 1, 1, 0, 0, 1); // 29 flush overrides hold
    add(1, 6, 0, 0, 7, 0, 0, 0, 0, 0, 0); // 30

    // Reset state while arst is high
    #2;
    chk("rst_sel", 0, 32'(fwd_sel), 0);
    chk("rst_stall", 0, 32'(stall), 0);
    chk("rst_sel3", 0, 32'(fwd_sel3), 0);
    chk("rst_stall3", 0, 32'(stall3), 0);
`ifdef FWD_HAZARD_PERF_EN
    chk("rst_perf_stall", 0, perf_stall_cnt, 0);
    chk("rst_perf_fwd", 0, perf_fwd_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].rs0, tbl[i].rs1,
            tbl[i].hold, tbl[i].flush);
      @(negedge clk);
      chk("sel0", i, 32'(fwd_sel[1:0]), 32'(tbl[i].e0));
      chk("sel1", i, 32'(fwd_sel[3:2]), 32'(tbl[i].e1));
      chk("stall", i, 32'(stall), 32'(tbl[i].es));
      @(posedge clk);
      #1;
    end

    // The asynchronous reset pulse in mid-stall drops stall at once.
    drive(1, 7, 1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 6, 0, 0, 7, 0, 0, 0);
    #2;
    chk("pre_arst_stall", 0, 32'(stall), 1);
    arst = 1'b1;
    #1;
    chk("arst_stall", 0, 32'(stall), 0);
    chk("arst_sel", 0, 32'(fwd_sel), 0);
    #1;
    arst = 1'b0;
    #1;
    chk("post_arst_stall", 0, 32'(stall), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Deeper pipeline: a load to x9, then a consumer of x9, gives two stall cycles.
    ex_valid3 = 1; ex_rd3 = 9; ex_reg_write3 = 1; ex_mem_read3 = 1; ex_rs3 = '0;
    @(posedge clk);
    #1;
    ex_rd3 = 6; ex_reg_write3 = 0; ex_mem_read3 = 0; ex_rs3 = {5'd0, 5'd9};
    #3;
    chk("d3_stall", 1, 32'(stall3), 1);
    chk("d3_sel0", 1, 32'(fwd_sel3[1:0]), 0);
    @(posedge clk);
    #4;
    chk("d3_stall", 2, 32'(stall3), 1);
    chk("d3_sel0", 2, 32'(fwd_sel3[1:0]), 0);
    @(posedge clk);
    #4;
    chk("d3_stall", 3, 32'(stall3), 0);
    chk("d3_sel0", 3, 32'(fwd_sel3[1:0]), 3);
    chk("d3_sel1", 3, 32'(fwd_sel3[3:2]), 0);
    @(posedge clk);
    #1;
    ex_valid3 = 0; ex_rs3 = '0;
    #3;
`ifdef FWD_HAZARD_PERF_EN
    chk("d3_perf_stall", 0, perf_stall_cnt3, 2);
    chk("d3_perf_fwd", 0, perf_fwd_cnt3, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the in-order pipeline. Generalises the EX-stage forwarding select to N source operands and D forwarding stages.
- Keeps its own shift register of in-flight destination records instead of sampling the rd fields of later stages.
- Drives the ALU operand muxes (fwd_sel) and a stall request that freezes IF/ID/EX and injects a bubble behind EX.

Parameters:
- NUM_SRC, 2: number of source operands of the EX instruction.
- FWD_DEPTH, 2: number of tracked stages after EX (1=MEM, 2=WB, ...); legal range 1..7.
- REG_AW, 5: register address width.
- LOAD_READY_STAGE, 2: first tracked stage at which load data is forwardable; legal range 1..FWD_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- ex_valid  in  1  EX holds a real instruction.
- ex_rd  in  REG_AW  EX destination register.
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rs  in  NUM_SRC*REG_AW  EX source registers; operand i is at bits [i*REG_AW +: REG_AW].
- hold  in  1  global freeze (memory wait): records do not move.
- flush  in  1  kill all in-flight records.
- fwd_sel  out  NUM_SRC*SW  per-operand select, SW=$clog2(FWD_DEPTH+1). 0=regfile, k=result of stage k.
- stall  out  1  load-use stall request, combinational.

Behaviour:
- Record per stage k (1..FWD_DEPTH): valid, rd, ld (is load). A record is a write candidate iff valid and rd!=0.
- Reset (arst=1, asynchronous): all record valid bits cleared. fwd_sel=0 and stall=0 for as long as arst is high and until a record matches.
- Update on each rising clk, priority: flush > hold > shift.
  - flush=1: all records invalid (also overrides hold).
  - hold=1: all records unchanged.
  - Otherwise: stage k takes stage k-1 for k>=2; the record leaving stage FWD_DEPTH is dropped.
  - Stage 1 takes {ex_valid & ex_reg_write & !stall, ex_rd, ex_mem_read}. When stall=1, stage 1 receives a bubble (valid=0).
- Ready rule: stage k is ready iff !ld or k>=LOAD_READY_STAGE.
- Forwarding, independently per operand i:
  - Find the youngest (smallest k) write candidate with rd==rs_i.
  - None: sel_i=0.
  - Found and ready: sel_i=k.
  - Found and not ready: sel_i=0 and hazard_i=1. Never fall through to an older stage.
- rs_i==0 always gives sel_i=0 and no hazard.
- stall = ex_valid & OR(hazard_i). Evaluated combinationally from current records and EX inputs, with no added latency.
- The consumer must not advance EX while stall=1.
- Stall length follows from the shift rule: load in stage k needs LOAD_READY_STAGE-k further shifts. With defaults, load immediately ahead gives exactly 1 stall cycle. hold=1 extends the stall for as long as hold is high.
- ex_valid=0: no stall, but fwd_sel still computed (don't-care for consumer).
- flush and stall in the same cycle: flush wins; next cycle has no records, so no stall.
- arst asserted mid-stall: stall drops asynchronously, since records clear.

Optional Feature:
- Macro FWD_HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_fwd_cnt[31:0], both cleared by arst and wrap-around (no saturation).
  - perf_stall_cnt increments on each clk where stall=1 & !hold.
  - perf_fwd_cnt increments by 1 on each clk where ex_valid & !stall & !hold and any sel_i!=0.
- Not defined: ports and counters absent; remaining behaviour identical.

Test Plan (defaults unless stated):
- ALU instr writing x5 shifted in; next cycle ex_rs={x0,x5}, ex_valid=1 -> fwd_sel op1=1, op0=0, stall=0. One shift later with same rs -> op1=2. After a third shift -> op1=0.
- Load to x7 shifted in; next cycle ex_rs op0=x7 -> stall=1 and op0=0 for exactly 1 cycle (EX held, bubble into stage 1). Following cycle -> stall=0, op0=2.
- Same load-use case with hold=1 for 3 cycles during the stall -> stall stays 1 for 4 cycles total, then op0=2.
- Stage1 and stage2 both write x3, ex_rs op0=op1=x3 -> both selects=1. A write to x0 followed by ex_rs=x0 -> select 0 and no stall.
- Load-use stall active, then flush=1 for one edge -> next cycle stall=0, all selects 0. arst pulse mid-stall -> stall=0 immediately, without waiting for a clk edge.
- FWD_DEPTH=3, LOAD_READY_STAGE=3, load to x9 followed by consumer of x9 -> 2 stall cycles, then op0=3. With FWD_HAZARD_PERF_EN: perf_stall_cnt=2, and perf_fwd_cnt=1 after the consumer issues.
